// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO: gates user requests against
// full/empty and drives the memory strobes, extended pointers and status flags.
module fifo_ctrl #(
   parameter int FIFO_ADDRESS_SIZE = 2,
   parameter int AF_LEVEL          = 3,
   parameter int AE_LEVEL          = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic                         rd_en,
   input  logic                         clr_err,
   output logic                         cw_en,
   output logic                         cr_en,
   output logic [FIFO_ADDRESS_SIZE:0]   w_ptr,
   output logic [FIFO_ADDRESS_SIZE:0]   r_ptr,
   output logic [FIFO_ADDRESS_SIZE:0]   count,
   output logic                         full,
   output logic                         empty,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic                         rvalid,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PW = FIFO_ADDRESS_SIZE + 1;
   localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   // The wrap bit distinguishes full (same index, different lap) from empty.
   assign empty        = (w_ptr == r_ptr);
   assign full         = (w_ptr[PW-1] != r_ptr[PW-1]) &&
                         (w_ptr[PW-2:0] == r_ptr[PW-2:0]);
   assign count        = w_ptr - r_ptr;
   assign almost_full  = (count >= AF_THRESH);
   assign almost_empty = (count <= AE_THRESH);

   assign cw_en = wr_en & ~full;
   assign cr_en = rd_en & ~empty;

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch and
      // every register here uses non-blocking assignment to avoid ordering races.
      if (!rst_n) begin
         w_ptr     <= '0;
         r_ptr     <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (cw_en) w_ptr <= w_ptr + PTR_ONE;
         if (cr_en) r_ptr <= r_ptr + PTR_ONE;
         rvalid    <= cr_en;
         // A fresh error on the clearing edge takes priority over clr_err.
         overflow  <= (overflow  & ~clr_err) | (wr_en & full);
         underflow <= (underflow & ~clr_err) | (rd_en & empty);
      end
   end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the synchronous FIFO, sitting directly upstream of the FIFO `memory` block. It accepts user write/read requests and gates them against full/empty. It produces the `cw_en`/`cr_en` strobes and the extended (wrap-bit) `w_ptr`/`r_ptr` that drive the memory. It also reports occupancy, watermark flags, sticky error flags and a read-data-valid strobe aligned to the memory's registered `rdata`.

## Interface
Parameters:
- `FIFO_ADDRESS_SIZE`, 2, address bits; depth D = 2**FIFO_ADDRESS_SIZE; pointers are FIFO_ADDRESS_SIZE+1 bits.
- `AF_LEVEL`, 3, `almost_full` asserts when count >= AF_LEVEL (range 1..D).
- `AE_LEVEL`, 1, `almost_empty` asserts when count <= AE_LEVEL (range 0..D-1).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset; **synchronous, active-low**; one clock, reset sampled on `clk` rising edge.
- `wr_en`  in  1  user write request.
- `rd_en`  in  1  user read request.
- `clr_err`  in  1  clears sticky `overflow`/`underflow`.
- `cw_en`  out  1  memory write strobe (accepted write).
- `cr_en`  out  1  memory read strobe (accepted read).
- `w_ptr`  out  FIFO_ADDRESS_SIZE+1  write pointer; MSB is wrap bit.
- `r_ptr`  out  FIFO_ADDRESS_SIZE+1  read pointer; MSB is wrap bit.
- `count`  out  FIFO_ADDRESS_SIZE+1  occupancy, 0..D.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1 each  status flags.
- `rvalid`  out  1  memory `rdata` valid this cycle.
- `overflow`, `underflow`  out  1 each  sticky error flags.

## Operation
- `cw_en = wr_en & ~full`; `cr_en = rd_en & ~empty`. Both are combinational from inputs and registered state.
- On a rising edge with `rst_n`=1:
  - `cw_en` → `w_ptr <= w_ptr + 1`.
  - `cr_en` → `r_ptr <= r_ptr + 1`.
  - Both pointers are modulo 2**(FIFO_ADDRESS_SIZE+1), so wrap-around is natural overflow of the extended pointer.
- `empty = (w_ptr == r_ptr)`.
- `full = (w_ptr[MSB] != r_ptr[MSB]) && (w_ptr[MSB-1:0] == r_ptr[MSB-1:0])`.
- `count = w_ptr - r_ptr`, truncated to FIFO_ADDRESS_SIZE+1 bits. This is exact for 0..D.
- Status flags and `count` are combinational from the registered pointers only, so they are glitch-free with respect to `wr_en`/`rd_en`.
- Simultaneous requests:
  - Not full and not empty: both accepted, count unchanged.
  - Full: read accepted, write rejected. There is no write-through on full.
  - Empty: write accepted, read rejected. There is no read-through on empty.
- `rvalid <= cr_en` (registered). This matches the memory's registered read, where `rdata` updates on the edge where `cr_en`=1.
- Sticky errors:
  - `overflow` sets on an edge with `wr_en & full`.
  - `underflow` sets on an edge with `rd_en & empty`.
  - `clr_err` clears both. A new error on the same edge as `clr_err` wins (flag stays set).
- Rejected requests change no pointer and emit no strobe.

## Timing
- Reset (`rst_n`=0 at a rising edge): outputs take these values.
  - `w_ptr`, `r_ptr` = 0; `count` = 0.
  - `empty` = 1, `full` = 0, `almost_full` = 0.
  - `almost_empty` = 1.
  - `rvalid`, `overflow`, `underflow` = 0.
- Reset overrides all requests in that cycle. A transfer in flight is dropped; `rvalid` is 0 on the cycle after reset.
- Before the first clock edge, outputs are undefined (synchronous reset).
- Write latency: the write is accepted at edge N. At edge N, `count`/`empty` update, so `empty`=0 from cycle N+1.
- Read latency: `cr_en` is high in cycle N. Memory `rdata` and `rvalid`=1 are both valid in cycle N+1.
- Back-to-back reads/writes are sustained at 1 per clock. Throughput is 1 word/cycle each direction.
- Full→read: `full` drops the cycle after the read edge. A write is then accepted in that cycle.

## Test plan
All scenarios use FIFO_ADDRESS_SIZE=2, D=4, AF_LEVEL=3, AE_LEVEL=1.
1. Reset check: hold `rst_n`=0 for 2 edges with `wr_en`=`rd_en`=1 → ptrs 0, `empty`=1, `almost_empty`=1, `full`=0, `rvalid`=0, `cw_en`=1/`cr_en`=0 after reset release.
2. Fill: 4 consecutive writes → `count` 1,2,3,4. `almost_full` from count 3, `full` at 4. `w_ptr`=3'b100, `r_ptr`=0.
3. Overflow: 5th write while full → `cw_en`=0, `w_ptr` unchanged, `overflow`=1 next cycle. `clr_err` pulse → 0. `clr_err` with `wr_en`&`full` on the same edge → stays 1.
4. Drain and underflow: 4 reads → `rvalid`=1 one cycle after each `cr_en`, `empty`=1 after 4th. 5th read → `cr_en`=0, `underflow`=1.
5. Wrap-around: 10 write/read pairs (write then read each 2 cycles) → pointers wrap 7→0 with `count` never exceeding 1, `full` never asserted.
6. Simultaneous: at count 2, `wr_en`=`rd_en`=1 for 3 cycles → count stays 2. At full with both set → only the read is accepted, count 4→3. At empty with both set → only the write is accepted, count 0→1.
